// File: rtl/ram_burst_ctrl_pkg.sv
// Shared types and default widths for the burst controller that masters the 1K x 8 synchronous RAM.
package ram_burst_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    W_LAST  = 3'd2,
    READ    = 3'd3,
    R_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/ram_burst_ctrl_bus_drv.sv
// Registered RAM strobes and the tristate driver for the shared data bus.
// The controller owns ram_data only while the registered cs and wr are both high.
module ram_burst_ctrl_bus_drv #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_d,
  input  logic              rd_d,
  input  logic              wr_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              ram_cs,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  logic [DATA_W-1:0] data_q;

  // Write wins if both are requested, so rd and wr can never be seen together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_cs   <= 1'b0;
      ram_rd   <= 1'b0;
      ram_wr   <= 1'b0;
      ram_addr <= '0;
      data_q   <= '0;
    end else begin
      ram_cs   <= cs_d;
      ram_rd   <= rd_d & ~wr_d;
      ram_wr   <= wr_d;
      ram_addr <= addr_d;
      data_q   <= data_d;
    end
  end

  assign ram_data = (ram_cs && ram_wr) ? data_q : 'z;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst read/write master for a synchronous RAM: command and write-data streams in,
// read-data stream out, RAM strobes and bus ownership handled by the bus driver.
module ram_burst_ctrl
  import ram_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_cs,
  output logic              ram_rd,
  output logic              ram_wr,
  output state_t            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; cmd and wdata
  // senders hold their payload until then; rdata has no ready and must be taken when valid.
  state_t            state, state_d;
  logic [ADDR_W-1:0] cur, cur_d;
  logic [LEN_W-1:0]  cnt, cnt_d;
  logic              cs_d, rd_d, wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              issue, issue_last, wr_done;
  logic              iss1, last1, iss2, last2;

  assign cmd_ready   = (state == IDLE);
  assign wdata_ready = (state == WRITE);
  assign dbg_state   = state;

  // cnt holds the beats still to go after the current one, so cnt==0 marks the last beat.
  always_comb begin
    state_d    = state;
    cur_d      = cur;
    cnt_d      = cnt;
    cs_d       = 1'b0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    addr_d     = ram_addr;
    data_d     = wdata;
    issue      = 1'b0;
    issue_last = 1'b0;
    wr_done    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cur_d = cmd_addr;
          cnt_d = cmd_len;
          if (cmd_write) begin
            state_d = WRITE;
          end else begin
            cs_d       = 1'b1;
            rd_d       = 1'b1;
            addr_d     = cmd_addr;
            cur_d      = cmd_addr + ADDR_W'(1);
            cnt_d      = cmd_len - LEN_W'(1);
            issue      = 1'b1;
            issue_last = (cmd_len == '0);
            state_d    = (cmd_len == '0) ? R_DRAIN : READ;
          end
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          cs_d   = 1'b1;
          wr_d   = 1'b1;
          addr_d = cur;
          data_d = wdata;
          cur_d  = cur + ADDR_W'(1);
          cnt_d  = cnt - LEN_W'(1);
          if (cnt == '0) state_d = W_LAST;
        end
      end
      W_LAST: begin
        wr_done = 1'b1;
        state_d = IDLE;
      end
      READ: begin
        cs_d   = 1'b1;
        rd_d   = 1'b1;
        addr_d = cur;
        issue  = 1'b1;
        cur_d  = cur + ADDR_W'(1);
        cnt_d  = cnt - LEN_W'(1);
        if (cnt == '0) begin
          issue_last = 1'b1;
          state_d    = R_DRAIN;
        end
      end
      R_DRAIN: begin
        // Keep the RAM selected on the last address so it drives the final word until capture.
        cs_d    = 1'b1;
        rd_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= '0;
      cnt         <= '0;
      iss1        <= 1'b0;
      last1       <= 1'b0;
      iss2        <= 1'b0;
      last2       <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      cur         <= cur_d;
      cnt         <= cnt_d;
      iss1        <= issue;
      last1       <= issue_last;
      iss2        <= iss1;
      last2       <= last1;
      rdata_valid <= iss2;
      if (iss2) rdata <= ram_data;
      done        <= (iss2 && last2) || wr_done;
    end
  end

  ram_burst_ctrl_bus_drv #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bus_drv (
    .clk      (clk),
    .rst      (rst),
    .cs_d     (cs_d),
    .rd_d     (rd_d),
    .wr_d     (wr_d),
    .addr_d   (addr_d),
    .data_d   (data_d),
    .ram_cs   (ram_cs),
    .ram_rd   (ram_rd),
    .ram_wr   (ram_wr),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl with a behavioural 1K x 8 synchronous RAM slave.
module tb_ram_burst_ctrl;
  import ram_burst_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, done;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic          ram_cs, ram_rd, ram_wr;
  state_t        dbg_state;

  ram_burst_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_cs(ram_cs),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // RAM slave: samples strobes on the edge, drives its output register while selected for read
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_data;
    if (ram_cs && ram_rd) ram_q <= mem[ram_addr];
  end
  assign ram_data = (ram_cs && ram_rd) ? ram_q : 'z;

  // scoreboard state and reference model
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] ref_mem [1024];
  int passes = 0;
  int total  = 0;
  int bus_err = 0;
  bit log_en = 0;
  bit log_cs[$];
  bit log_rd[$];
  bit log_wr[$];

  always @(negedge clk) begin
    if (ram_rd && ram_wr) bus_err++;
    if (ram_cs && ram_wr && $isunknown(ram_data)) bus_err++;
    if (log_en) begin
      log_cs.push_back(ram_cs);
      log_rd.push_back(ram_rd);
      log_wr.push_back(ram_wr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  // driver tasks: called on a falling edge, return on a falling edge
  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int t;
    t = 0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input int stall_at, input bit rand_stall);
    logic [DW-1:0] d;
    int n;
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      n = 0;
      if (i == stall_at) n = 2;
      else if (rand_stall && $urandom_range(0, 3) == 0) n = $urandom_range(1, 2);
      wdata_valid = 1'b0;
      for (int s = 0; s < n; s++) begin
        @(negedge clk);
        check("stall_cs", {31'd0, ram_cs}, 32'd0);
      end
      d = wr_q.pop_front();
      wdata = d;
      wdata_valid = 1'b1;
      check("wdata_ready", {31'd0, wdata_ready}, 32'd1);
      @(negedge clk);
      check("wbeat", {12'd0, ram_cs, ram_wr, ram_addr, ram_data},
            {12'd0, 1'b1, 1'b1, a + AW'(i), d});
      ref_mem[a + AW'(i)] = d;
    end
    wdata_valid = 1'b0;
    check("wlast_ready", {31'd0, wdata_ready}, 32'd0);
    @(negedge clk);
    check("wdone", {30'd0, done, ram_cs}, 32'd2);
  endtask

  task automatic read_collect(input logic [LW-1:0] l);
    logic [DW-1:0] e;
    @(negedge clk);
    for (int i = 0; i <= int'(l); i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("rbeat", {22'd0, rdata_valid, rdata, done}, {22'd0, 1'b1, e, i == int'(l)});
    end
    @(negedge clk);
    check("rend", {30'd0, rdata_valid, done}, 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] l);
    for (int i = 0; i <= int'(l); i++) exp_q.push_back(ref_mem[a + AW'(i)]);
    send_cmd(1'b0, a, l);
    read_collect(l);
  endtask

  typedef struct {
    logic [AW-1:0]     addr;
    logic [LW-1:0]     len;
    logic [3:0][DW-1:0] data;
    int                stall_at;
    logic [3:0][DW-1:0] exp;
  } vec_t;

  vec_t tbl[3];

  initial begin
    int last_rd, first_wr;
    bit gap_ok;
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;

    tbl[0] = '{addr: 10'h005, len: 8'd0, data: {8'h00, 8'h00, 8'h00, 8'hA5}, stall_at: -1,
               exp: {8'h00, 8'h00, 8'h00, 8'hA5}};
    tbl[1] = '{addr: 10'h010, len: 8'd3, data: {8'h44, 8'h33, 8'h22, 8'h11}, stall_at: 2,
               exp: {8'h44, 8'h33, 8'h22, 8'h11}};
    tbl[2] = '{addr: 10'h3FE, len: 8'd3, data: {8'h04, 8'h03, 8'h02, 8'h01}, stall_at: -1,
               exp: {8'h04, 8'h03, 8'h02, 8'h01}};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {29'd0, dbg_state}, {29'd0, IDLE});
    check("reset_strobes", {29'd0, ram_cs, ram_rd, ram_wr}, 32'd0);
    check("reset_outs", {22'd0, ram_addr}, 32'd0);
    check("reset_rdata", {22'd0, rdata_valid, done, rdata}, 32'd0);
    check("reset_ready", {30'd0, cmd_ready, wdata_ready}, 32'd2);
    rst = 1'b0;
    @(negedge clk);

    // fill the whole RAM with max-length write bursts
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 256; i++) wr_q.push_back(DW'($urandom));
      do_write(AW'(b * 256), 8'd255, -1, b[0]);
    end

    // directed table: write, check RAM contents, read back as one burst
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k <= int'(tbl[v].len); k++) wr_q.push_back(tbl[v].data[k]);
      do_write(tbl[v].addr, tbl[v].len, tbl[v].stall_at, 1'b0);
      for (int k = 0; k <= int'(tbl[v].len); k++)
        check("mem_content", {24'd0, mem[tbl[v].addr + AW'(k)]}, {24'd0, tbl[v].exp[k]});
      for (int k = 0; k <= int'(tbl[v].len); k++) exp_q.push_back(tbl[v].exp[k]);
      send_cmd(1'b0, tbl[v].addr, tbl[v].len);
      read_collect(tbl[v].len);
    end

    // max read burst from address 0
    do_read(10'h000, 8'd255);

    // read burst immediately followed by a write command held valid
    for (int i = 0; i < 4; i++) wr_q.push_back(DW'($urandom));
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_mem[10'h100 + AW'(i)]);
    send_cmd(1'b0, 10'h100, 8'd3);
    log_en = 1'b1;
    fork
      read_collect(8'd3);
      do_write(10'h200, 8'd3, -1, 1'b0);
    join
    log_en = 1'b0;
    last_rd = -1;
    first_wr = -1;
    foreach (log_rd[i]) if (log_rd[i]) last_rd = i;
    foreach (log_wr[i]) if (log_wr[i] && first_wr < 0) first_wr = i;
    gap_ok = (last_rd >= 0) && (first_wr > last_rd + 1);
    for (int i = last_rd + 1; i < first_wr && gap_ok; i++) if (log_cs[i]) gap_ok = 1'b0;
    check("turnaround_gap", {31'd0, gap_ok}, 32'd1);

    // randomized bursts against the reference memory
    for (int r = 0; r < 14; r++) begin
      ra = AW'($urandom_range(0, 1023));
      rl = LW'($urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(rl); i++) wr_q.push_back(DW'($urandom));
        do_write(ra, rl, -1, 1'b1);
      end else begin
        do_read(ra, rl);
      end
    end

    // reset two cycles into a read burst abandons it
    send_cmd(1'b0, 10'h020, 8'd7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_strobes", {29'd0, ram_cs, ram_rd, ram_wr}, 32'd0);
    check("rst_rdata", {30'd0, rdata_valid, done}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_quiet", {29'd0, rdata_valid, done, ram_cs}, 32'd0);
    end
    do_read(10'h005, 8'd0);

    check("bus_protocol", bus_err, 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
